// File: rtl/lightbike_pkg.sv
// Shared constants and types for the lightbike player-input path:
// orientation codes, PS/2 set-2 scancodes, decoder states and FIFO entries.
package lightbike_pkg;

  localparam logic [1:0] DIR_UP    = 2'd0;
  localparam logic [1:0] DIR_RIGHT = 2'd1;
  localparam logic [1:0] DIR_DOWN  = 2'd2;
  localparam logic [1:0] DIR_LEFT  = 2'd3;

  localparam logic PLAYER_BLUE = 1'b0;
  localparam logic PLAYER_RED  = 1'b1;

  localparam logic [7:0] SC_EXT   = 8'hE0;
  localparam logic [7:0] SC_BRK   = 8'hF0;
  localparam logic [7:0] SC_W     = 8'h1D;
  localparam logic [7:0] SC_D     = 8'h23;
  localparam logic [7:0] SC_S     = 8'h1B;
  localparam logic [7:0] SC_A     = 8'h1C;
  localparam logic [7:0] SC_UP    = 8'h75;
  localparam logic [7:0] SC_RIGHT = 8'h74;
  localparam logic [7:0] SC_DOWN  = 8'h72;
  localparam logic [7:0] SC_LEFT  = 8'h6B;

  typedef enum logic [1:0] {
    DEC_IDLE,
    DEC_EXT,
    DEC_BRK,
    DEC_EXT_BRK
  } dec_state_t;

  typedef struct packed {
    logic       player;
    logic [1:0] dir;
  } cmd_t;

  // A turn is useful only if it is neither a repeat nor a 180-degree reversal.
  function automatic logic turn_allowed(input logic [1:0] dir, input logic [1:0] last);
    return (dir != last) && ((dir ^ last) != 2'd2);
  endfunction

endpackage

// File: rtl/key_inject_writer_if.sv
// Register-file inject port: the writer drives the request, the regfile side
// supplies the processor write enable that takes priority.
interface key_inject_writer_if;
  logic        proc_wen;
  logic        inj_wen;
  logic [4:0]  inj_rd;
  logic [31:0] inj_data;

  modport master (input proc_wen, output inj_wen, output inj_rd, output inj_data);
  modport slave  (output proc_wen, input inj_wen, input inj_rd, input inj_data);
endinterface

// File: rtl/cmd_fifo.sv
// Small synchronous FIFO; a push while full is accepted when a pop happens on
// the same edge. A synchronous clear empties it without touching storage.
module cmd_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 3
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             clear,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] head,
  output logic             full,
  output logic             empty
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [AW:0] FULL_COUNT = (AW + 1)'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    rd_ptr;
  logic [AW-1:0]    wr_ptr;
  logic [AW:0]      count;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == FULL_COUNT);
  assign empty   = (count == '0);
  assign do_pop  = pop & ~empty & ~clear;
  assign do_push = push & (~full | do_pop) & ~clear;
  assign head    = mem[rd_ptr];

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else if (clear) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/key_inject_writer.sv
// Decodes PS/2 scancodes into per-player turn commands, queues them, and
// injects each into the register file in cycles the processor leaves free.
module key_inject_writer
  import lightbike_pkg::*;
#(
  parameter logic [4:0] BLUE_ORIENT_REG = 5'd25,
  parameter logic [4:0] RED_ORIENT_REG  = 5'd26,
  parameter int         FIFO_DEPTH      = 4
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic                       key_valid,
  input  logic [7:0]                 key_code,
  input  logic                       masterSwitch,
  key_inject_writer_if.master        bus,
  output logic                       fifo_full,
  output logic                       overflow
);

  dec_state_t state;
  dec_state_t state_next;
  logic       ev_valid;
  logic       ev_player;
  logic [1:0] ev_dir;
  logic [1:0] last_blue;
  logic [1:0] last_red;
  logic [1:0] last_sel;
  logic       turn_ok;
  logic       fifo_empty;
  logic       pop;
  cmd_t       push_cmd;
  cmd_t       head_cmd;
  logic [4:0] sel_reg;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) state <= DEC_IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    if (!masterSwitch) begin
      state_next = DEC_IDLE;
    end else if (key_valid) begin
      case (state)
        DEC_IDLE: begin
          if (key_code == SC_EXT)      state_next = DEC_EXT;
          else if (key_code == SC_BRK) state_next = DEC_BRK;
          else                         state_next = DEC_IDLE;
        end
        DEC_EXT: begin
          if (key_code == SC_BRK) state_next = DEC_EXT_BRK;
          else                    state_next = DEC_IDLE;
        end
        default: state_next = DEC_IDLE;
      endcase
    end
  end

  // Make codes only count in IDLE (blue) or right after E0 (red).
  always_comb begin
    ev_valid  = 1'b0;
    ev_player = PLAYER_BLUE;
    ev_dir    = DIR_UP;
    if (masterSwitch && key_valid) begin
      case (state)
        DEC_IDLE: begin
          ev_player = PLAYER_BLUE;
          case (key_code)
            SC_W:    begin ev_valid = 1'b1; ev_dir = DIR_UP;    end
            SC_D:    begin ev_valid = 1'b1; ev_dir = DIR_RIGHT; end
            SC_S:    begin ev_valid = 1'b1; ev_dir = DIR_DOWN;  end
            SC_A:    begin ev_valid = 1'b1; ev_dir = DIR_LEFT;  end
            default: ev_valid = 1'b0;
          endcase
        end
        DEC_EXT: begin
          ev_player = PLAYER_RED;
          case (key_code)
            SC_UP:    begin ev_valid = 1'b1; ev_dir = DIR_UP;    end
            SC_RIGHT: begin ev_valid = 1'b1; ev_dir = DIR_RIGHT; end
            SC_DOWN:  begin ev_valid = 1'b1; ev_dir = DIR_DOWN;  end
            SC_LEFT:  begin ev_valid = 1'b1; ev_dir = DIR_LEFT;  end
            default:  ev_valid = 1'b0;
          endcase
        end
        default: ev_valid = 1'b0;
      endcase
    end
  end

  assign last_sel = ev_player ? last_red : last_blue;
  assign turn_ok  = ev_valid & turn_allowed(ev_dir, last_sel);
  assign push_cmd = '{player: ev_player, dir: ev_dir};

  // Heading follows every accepted turn, even one the full FIFO then drops.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      last_blue <= DIR_RIGHT;
      last_red  <= DIR_LEFT;
    end else if (!masterSwitch) begin
      last_blue <= DIR_RIGHT;
      last_red  <= DIR_LEFT;
    end else if (turn_ok) begin
      if (ev_player == PLAYER_RED) last_red  <= ev_dir;
      else                         last_blue <= ev_dir;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset)                           overflow <= 1'b0;
    else if (turn_ok && fifo_full && !pop) overflow <= 1'b1;
  end

  cmd_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH ($bits(cmd_t))
  ) u_fifo (
    .clock     (clock),
    .reset     (reset),
    .clear     (~masterSwitch),
    .push      (turn_ok),
    .push_data (push_cmd),
    .pop       (pop),
    .head      (head_cmd),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  // An entry aimed at register 0 is still popped, just never written.
  assign pop          = masterSwitch & ~fifo_empty & ~bus.proc_wen;
  assign sel_reg      = head_cmd.player ? RED_ORIENT_REG : BLUE_ORIENT_REG;
  assign bus.inj_wen  = pop & (sel_reg != 5'd0);
  assign bus.inj_rd   = bus.inj_wen ? sel_reg : 5'd0;
  assign bus.inj_data = bus.inj_wen ? {30'b0, head_cmd.dir} : 32'd0;

endmodule

// File: tb/tb_key_inject_writer.sv
// Directed bench for key_inject_writer: decoding, turn filtering, stall,
// overflow, masterSwitch flush and asynchronous reset mid-sequence.
module tb_key_inject_writer;

  logic       clock;
  logic       reset;
  logic       key_valid;
  logic [7:0] key_code;
  logic       masterSwitch;
  logic       fifo_full;
  logic       overflow;
  int         checks;
  int         failures;

  key_inject_writer_if bus();

  key_inject_writer dut (
    .clock        (clock),
    .reset        (reset),
    .key_valid    (key_valid),
    .key_code     (key_code),
    .masterSwitch (masterSwitch),
    .bus          (bus),
    .fifo_full    (fifo_full),
    .overflow     (overflow)
  );

  always #5 clock = ~clock;

  // Every task starts and ends 1 time unit after a rising edge.
  task automatic send_byte(input logic [7:0] code);
    key_valid = 1'b1;
    key_code  = code;
    @(posedge clock);
    #1;
    key_valid = 1'b0;
    key_code  = 8'h00;
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b0;
    repeat (2) @(posedge clock);
    #1;
    reset = 1'b1;
  endtask

  task automatic test_reset();
    #1;
    checks++;
    if (bus.inj_wen !== 1'b0 || bus.inj_rd !== 5'd0 || bus.inj_data !== 32'd0) begin
      failures++;
      $display("[TB] FAIL reset_outputs got wen=%0b rd=%0d data=%0d exp wen=0 rd=0 data=0",
               bus.inj_wen, bus.inj_rd, bus.inj_data);
    end
    repeat (2) @(posedge clock);
    #1;
    reset = 1'b1;
    #1;
    checks++;
    if (fifo_full !== 1'b0 || overflow !== 1'b0) begin
      failures++;
      $display("[TB] FAIL reset_flags got full=%0b ovf=%0b exp full=0 ovf=0", fifo_full, overflow);
    end
    tick();
  endtask

  task automatic test_blue_basic();
    send_byte(8'h1D);
    checks++;
    if (bus.inj_wen !== 1'b1 || bus.inj_rd !== 5'd25 || bus.inj_data !== 32'd0) begin
      failures++;
      $display("[TB] FAIL blue_up got wen=%0b rd=%0d data=%0d exp wen=1 rd=25 data=0",
               bus.inj_wen, bus.inj_rd, bus.inj_data);
    end
    tick();
    checks++;
    if (bus.inj_wen !== 1'b0) begin
      failures++;
      $display("[TB] FAIL blue_single_write got wen=%0b exp 0", bus.inj_wen);
    end
  endtask

  task automatic test_red_filter();
    // Red starts facing LEFT: LEFT is a repeat, RIGHT a reversal.
    send_byte(8'hE0);
    send_byte(8'h6B);
    checks++;
    if (bus.inj_wen !== 1'b0) begin
      failures++;
      $display("[TB] FAIL red_left_repeat got wen=%0b exp 0", bus.inj_wen);
    end
    send_byte(8'hE0);
    send_byte(8'h74);
    checks++;
    if (bus.inj_wen !== 1'b0) begin
      failures++;
      $display("[TB] FAIL red_right_reversal got wen=%0b exp 0", bus.inj_wen);
    end
    send_byte(8'hE0);
    send_byte(8'h72);
    checks++;
    if (bus.inj_wen !== 1'b1 || bus.inj_rd !== 5'd26 || bus.inj_data !== 32'd2) begin
      failures++;
      $display("[TB] FAIL red_down got wen=%0b rd=%0d data=%0d exp wen=1 rd=26 data=2",
               bus.inj_wen, bus.inj_rd, bus.inj_data);
    end
    tick();
    send_byte(8'hE0);
    send_byte(8'h74);
    checks++;
    if (bus.inj_wen !== 1'b1 || bus.inj_rd !== 5'd26 || bus.inj_data !== 32'd1) begin
      failures++;
      $display("[TB] FAIL red_right_after_down got wen=%0b rd=%0d data=%0d exp wen=1 rd=26 data=1",
               bus.inj_wen, bus.inj_rd, bus.inj_data);
    end
    tick();
  endtask

  task automatic test_breaks_reversal();
    send_byte(8'hF0);
    send_byte(8'h1D);
    checks++;
    if (bus.inj_wen !== 1'b0) begin
      failures++;
      $display("[TB] FAIL blue_break got wen=%0b exp 0", bus.inj_wen);
    end
    send_byte(8'hE0);
    send_byte(8'hF0);
    send_byte(8'h75);
    checks++;
    if (bus.inj_wen !== 1'b0) begin
      failures++;
      $display("[TB] FAIL red_break got wen=%0b exp 0", bus.inj_wen);
    end
    do_reset();
    send_byte(8'h1C);
    checks++;
    if (bus.inj_wen !== 1'b0) begin
      failures++;
      $display("[TB] FAIL blue_reversal got wen=%0b exp 0", bus.inj_wen);
    end
    send_byte(8'h1B);
    checks++;
    if (bus.inj_wen !== 1'b1 || bus.inj_rd !== 5'd25 || bus.inj_data !== 32'd2) begin
      failures++;
      $display("[TB] FAIL blue_down got wen=%0b rd=%0d data=%0d exp wen=1 rd=25 data=2",
               bus.inj_wen, bus.inj_rd, bus.inj_data);
    end
    tick();
  endtask

  task automatic test_stall_overflow();
    logic [7:0] codes [6];
    codes = '{8'h1D, 8'h23, 8'h1B, 8'h1C, 8'h1D, 8'h23};
    do_reset();
    bus.proc_wen = 1'b1;
    for (int i = 0; i < 6; i++) begin
      send_byte(codes[i]);
      checks++;
      if (bus.inj_wen !== 1'b0) begin
        failures++;
        $display("[TB] FAIL stall_no_write[%0d] got wen=%0b exp 0", i, bus.inj_wen);
      end
      checks++;
      if (fifo_full !== (i >= 3)) begin
        failures++;
        $display("[TB] FAIL stall_full[%0d] got %0b exp %0b", i, fifo_full, (i >= 3));
      end
      checks++;
      if (overflow !== (i >= 4)) begin
        failures++;
        $display("[TB] FAIL stall_overflow[%0d] got %0b exp %0b", i, overflow, (i >= 4));
      end
    end
    bus.proc_wen = 1'b0;
    #1;
    for (int k = 0; k < 4; k++) begin
      checks++;
      if (bus.inj_wen !== 1'b1 || bus.inj_rd !== 5'd25 || bus.inj_data !== 32'(k)) begin
        failures++;
        $display("[TB] FAIL drain[%0d] got wen=%0b rd=%0d data=%0d exp wen=1 rd=25 data=%0d",
                 k, bus.inj_wen, bus.inj_rd, bus.inj_data, k);
      end
      tick();
    end
    checks++;
    if (bus.inj_wen !== 1'b0 || fifo_full !== 1'b0 || overflow !== 1'b1) begin
      failures++;
      $display("[TB] FAIL drain_done got wen=%0b full=%0b ovf=%0b exp wen=0 full=0 ovf=1",
               bus.inj_wen, fifo_full, overflow);
    end
  endtask

  task automatic test_master_switch();
    // last_blue is RIGHT here: UP then RIGHT both queue.
    bus.proc_wen = 1'b1;
    send_byte(8'h1D);
    send_byte(8'h23);
    masterSwitch = 1'b0;
    bus.proc_wen = 1'b0;
    #1;
    checks++;
    if (bus.inj_wen !== 1'b0) begin
      failures++;
      $display("[TB] FAIL ms_low_no_write got wen=%0b exp 0", bus.inj_wen);
    end
    send_byte(8'h1B);
    tick();
    masterSwitch = 1'b1;
    #1;
    checks++;
    if (bus.inj_wen !== 1'b0 || fifo_full !== 1'b0 || overflow !== 1'b1) begin
      failures++;
      $display("[TB] FAIL ms_flushed got wen=%0b full=%0b ovf=%0b exp wen=0 full=0 ovf=1",
               bus.inj_wen, fifo_full, overflow);
    end
    send_byte(8'h23);
    checks++;
    if (bus.inj_wen !== 1'b0) begin
      failures++;
      $display("[TB] FAIL ms_last_blue_reset got wen=%0b exp 0", bus.inj_wen);
    end
    send_byte(8'h1D);
    checks++;
    if (bus.inj_wen !== 1'b1 || bus.inj_data !== 32'd0) begin
      failures++;
      $display("[TB] FAIL ms_resume got wen=%0b data=%0d exp wen=1 data=0", bus.inj_wen, bus.inj_data);
    end
    tick();
  endtask

  task automatic test_reset_mid_sequence();
    // last_blue is UP: RIGHT queues one entry before the E0 prefix.
    bus.proc_wen = 1'b1;
    send_byte(8'h23);
    send_byte(8'hE0);
    reset = 1'b0;
    #1;
    checks++;
    if (bus.inj_wen !== 1'b0 || bus.inj_rd !== 5'd0 || bus.inj_data !== 32'd0 ||
        fifo_full !== 1'b0 || overflow !== 1'b0) begin
      failures++;
      $display("[TB] FAIL mid_reset_outputs got wen=%0b rd=%0d data=%0d full=%0b ovf=%0b exp all 0",
               bus.inj_wen, bus.inj_rd, bus.inj_data, fifo_full, overflow);
    end
    tick();
    tick();
    reset = 1'b1;
    bus.proc_wen = 1'b0;
    send_byte(8'h75);
    checks++;
    if (bus.inj_wen !== 1'b0) begin
      failures++;
      $display("[TB] FAIL mid_reset_fresh_decode got wen=%0b exp 0", bus.inj_wen);
    end
    tick();
    checks++;
    if (bus.inj_wen !== 1'b0) begin
      failures++;
      $display("[TB] FAIL mid_reset_idle got wen=%0b exp 0", bus.inj_wen);
    end
    send_byte(8'h1D);
    checks++;
    if (bus.inj_wen !== 1'b1 || bus.inj_rd !== 5'd25 || bus.inj_data !== 32'd0) begin
      failures++;
      $display("[TB] FAIL mid_reset_blue_up got wen=%0b rd=%0d data=%0d exp wen=1 rd=25 data=0",
               bus.inj_wen, bus.inj_rd, bus.inj_data);
    end
    tick();
  endtask

  initial begin
    checks       = 0;
    failures     = 0;
    clock        = 1'b0;
    reset        = 1'b0;
    key_valid    = 1'b0;
    key_code     = 8'h00;
    masterSwitch = 1'b1;
    bus.proc_wen = 1'b0;

    test_reset();
    test_blue_basic();
    test_red_filter();
    test_breaks_reversal();
    test_stall_overflow();
    test_master_switch();
    test_reset_mid_sequence();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
